// File: rtl/xor_fold_sched.sv
// xor_fold_sched: round-robin scheduler sharing one external two-lane 32->16 XOR-fold datapath among NREQ requesters.
// Latency: handshake to out_valid is lvl+1 cycles (2/3/4 cycles for folds to 16/8/4 bits).
// Backpressure: the result is held in OUT until out_ready; no request is granted while busy.
module xor_fold_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*2-1:0]  req_lvl,
    output logic [31:0]        dp_a,
    output logic [31:0]        dp_b,
    input  logic [15:0]        dp_aa,
    input  logic [15:0]        dp_bb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDW-1:0]     out_id,
    output logic [15:0]        out_a,
    output logic [15:0]        out_b,
    output logic [1:0]         out_lvl,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, FOLD, OUT} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id;
    logic [31:0]    wa;
    logic [31:0]    wb;
    logic [15:0]    ra;
    logic [15:0]    rb;
    logic [1:0]     cnt;
    logic [1:0]     lvl;

    logic [IDW-1:0] gnt;
    logic           gnt_found;
    logic [31:0]    gnt_a;
    logic [31:0]    gnt_b;
    logic [1:0]     gnt_lvl;

    // Pick the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt       = IDW'(idx);
                gnt_found = 1'b1;
            end
        end
    end

    // Select the granted requester's operands; level 0 is promoted to 1.
    always_comb begin
        gnt_a   = req_a[32*int'(gnt) +: 32];
        gnt_b   = req_b[32*int'(gnt) +: 32];
        gnt_lvl = req_lvl[2*int'(gnt) +: 2];
        if (gnt_lvl == 2'd0) begin
            gnt_lvl = 2'd1;
        end
    end

    // Accept strobe only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && gnt_found) begin
            req_ready[gnt] = 1'b1;
        end
    end

    // Datapath operands: spread the previous partial result so the 32->16 fold halves it again; quiet outside FOLD.
    always_comb begin
        dp_a = '0;
        dp_b = '0;
        if (state == FOLD) begin
            case (cnt)
                2'd0: begin
                    dp_a = wa;
                    dp_b = wb;
                end
                2'd1: begin
                    dp_a = {8'b0, ra[15:8], 8'b0, ra[7:0]};
                    dp_b = {8'b0, rb[15:8], 8'b0, rb[7:0]};
                end
                default: begin
                    dp_a = {12'b0, ra[7:4], 12'b0, ra[3:0]};
                    dp_b = {12'b0, rb[7:4], 12'b0, rb[3:0]};
                end
            endcase
        end
    end

    // Results are presented straight from the work/capture registers.
    assign out_a   = ra;
    assign out_b   = rb;
    assign out_id  = id;
    assign out_lvl = lvl;

    // Control FSM: grant, iterate the datapath lvl times, hold the result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id        <= '0;
            wa        <= '0;
            wb        <= '0;
            ra        <= '0;
            rb        <= '0;
            cnt       <= '0;
            lvl       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        wa    <= gnt_a;
                        wb    <= gnt_b;
                        lvl   <= gnt_lvl;
                        id    <= gnt;
                        cnt   <= 2'd0;
                        busy  <= 1'b1;
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    ra  <= dp_aa;
                    rb  <= dp_bb;
                    cnt <= cnt + 2'd1;
                    if (cnt == lvl - 2'd1) begin
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        rr_ptr    <= (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
